// File: rtl/picorv32_sram_responder_if.sv
// ============================================================================
// Module   : picorv32_sram_responder_if
// Purpose  : PicoRV32 native memory bus plus imem loader write port.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface picorv32_sram_responder_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                  mem_valid;
  logic                  mem_instr;
  logic [31:0]           mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [3:0]            mem_wstrb;
  logic                  mem_ready;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  oob_err;
  logic                  ld_valid;
  logic [ADDR_WIDTH-1:0] ld_addr;
  logic [DATA_WIDTH-1:0] ld_data;
  logic                  ld_ready;

  modport master (
    output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    output ld_valid, ld_addr, ld_data,
    input  mem_ready, mem_rdata, oob_err, ld_ready
  );

  modport slave (
    input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    input  ld_valid, ld_addr, ld_data,
    output mem_ready, mem_rdata, oob_err, ld_ready
  );
endinterface

`default_nettype wire

// File: rtl/picorv32_sram_responder.sv
// ============================================================================
// Module   : picorv32_sram_responder
// Purpose  : Handshaked PicoRV32 responder for two OpenRAM macros (imem/dmem)
//            with read-modify-write byte stores and an imem loader port.
// Revision : 1.0
// ============================================================================
`default_nettype none

module picorv32_sram_responder #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  wire                         clk,
  input  wire                         resetn,
  picorv32_sram_responder_if.slave    bus,
  output logic                        imem_csb,
  output logic                        imem_web,
  output logic [ADDR_WIDTH:0]         imem_addr,
  output logic [DATA_WIDTH-1:0]       imem_din,
  input  wire  [DATA_WIDTH-1:0]       imem_dout,
  output logic                        dmem_csb,
  output logic                        dmem_web,
  output logic [ADDR_WIDTH:0]         dmem_addr,
  output logic [DATA_WIDTH-1:0]       dmem_din,
  input  wire  [DATA_WIDTH-1:0]       dmem_dout
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_RD_ISSUE = 3'd1;
  localparam logic [2:0] S_RD_CAPT  = 3'd2;
  localparam logic [2:0] S_WRITE    = 3'd3;
  localparam logic [2:0] S_RESP     = 3'd4;
  localparam logic [2:0] S_LD_WRITE = 3'd5;

  localparam int NBYTES = DATA_WIDTH / 8;

  logic [2:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] req_idx_q, req_idx_d;
  logic [DATA_WIDTH-1:0] req_wdata_q, req_wdata_d;
  logic [3:0]            req_wstrb_q, req_wstrb_d;
  logic                  req_imem_q, req_imem_d;

  logic                  mem_ready_q, mem_ready_d;
  logic                  oob_err_q, oob_err_d;
  logic                  ld_ready_q, ld_ready_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic                  imem_csb_q, imem_csb_d, imem_web_q, imem_web_d;
  logic                  dmem_csb_q, dmem_csb_d, dmem_web_q, dmem_web_d;
  logic [ADDR_WIDTH:0]   imem_addr_q, imem_addr_d, dmem_addr_q, dmem_addr_d;
  logic [DATA_WIDTH-1:0] imem_din_q, imem_din_d, dmem_din_q, dmem_din_d;

  logic                  oob;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] merged;

  assign oob     = (|bus.mem_addr[31:ADDR_WIDTH+2]) | (|bus.mem_addr[1:0]);
  assign rd_word = req_imem_q ? imem_dout : dmem_dout;

  always_comb begin
    merged = rd_word;
    for (int i = 0; i < NBYTES; i++) begin
      if (req_wstrb_q[i]) merged[8*i +: 8] = req_wdata_q[8*i +: 8];
    end
  end

  // State register together with every registered output and request latch.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      req_idx_q   <= '0;
      req_wdata_q <= '0;
      req_wstrb_q <= '0;
      req_imem_q  <= 1'b0;
      mem_ready_q <= 1'b0;
      oob_err_q   <= 1'b0;
      ld_ready_q  <= 1'b0;
      rdata_q     <= '0;
      imem_csb_q  <= 1'b1;
      imem_web_q  <= 1'b1;
      imem_addr_q <= '0;
      imem_din_q  <= '0;
      dmem_csb_q  <= 1'b1;
      dmem_web_q  <= 1'b1;
      dmem_addr_q <= '0;
      dmem_din_q  <= '0;
    end else begin
      state_q     <= state_d;
      req_idx_q   <= req_idx_d;
      req_wdata_q <= req_wdata_d;
      req_wstrb_q <= req_wstrb_d;
      req_imem_q  <= req_imem_d;
      mem_ready_q <= mem_ready_d;
      oob_err_q   <= oob_err_d;
      ld_ready_q  <= ld_ready_d;
      rdata_q     <= rdata_d;
      imem_csb_q  <= imem_csb_d;
      imem_web_q  <= imem_web_d;
      imem_addr_q <= imem_addr_d;
      imem_din_q  <= imem_din_d;
      dmem_csb_q  <= dmem_csb_d;
      dmem_web_q  <= dmem_web_d;
      dmem_addr_q <= dmem_addr_d;
      dmem_din_q  <= dmem_din_d;
    end
  end

  // ld_ready_q blocks re-accepting a loader word the loader has not yet dropped.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (bus.mem_valid) begin
          if (oob)                          state_d = S_RESP;
          else if (bus.mem_wstrb == 4'hF)   state_d = S_WRITE;
          else                              state_d = S_RD_ISSUE;
        end else if (bus.ld_valid && !ld_ready_q) begin
          state_d = S_LD_WRITE;
        end
      end
      S_RD_ISSUE: state_d = S_RD_CAPT;
      S_RD_CAPT:  state_d = (req_wstrb_q != 4'h0) ? S_WRITE : S_RESP;
      S_WRITE:    state_d = S_RESP;
      S_RESP:     state_d = S_IDLE;
      S_LD_WRITE: state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Macro controls are computed one cycle ahead so they leave the flops clean.
  always_comb begin
    req_idx_d   = req_idx_q;
    req_wdata_d = req_wdata_q;
    req_wstrb_d = req_wstrb_q;
    req_imem_d  = req_imem_q;
    mem_ready_d = 1'b0;
    oob_err_d   = 1'b0;
    ld_ready_d  = 1'b0;
    rdata_d     = rdata_q;
    imem_csb_d  = 1'b1;
    imem_web_d  = 1'b1;
    imem_addr_d = imem_addr_q;
    imem_din_d  = imem_din_q;
    dmem_csb_d  = 1'b1;
    dmem_web_d  = 1'b1;
    dmem_addr_d = dmem_addr_q;
    dmem_din_d  = dmem_din_q;
    case (state_q)
      S_IDLE: begin
        if (bus.mem_valid) begin
          req_idx_d   = bus.mem_addr[ADDR_WIDTH+1:2];
          req_wdata_d = bus.mem_wdata;
          req_wstrb_d = bus.mem_wstrb;
          req_imem_d  = bus.mem_instr && (bus.mem_wstrb == 4'h0);
          if (oob) begin
            mem_ready_d = 1'b1;
            oob_err_d   = 1'b1;
            rdata_d     = '0;
          end else if (bus.mem_wstrb == 4'h0) begin
            if (bus.mem_instr) begin
              imem_csb_d  = 1'b0;
              imem_addr_d = {1'b0, bus.mem_addr[ADDR_WIDTH+1:2]};
            end else begin
              dmem_csb_d  = 1'b0;
              dmem_addr_d = {1'b0, bus.mem_addr[ADDR_WIDTH+1:2]};
            end
          end else begin
            dmem_csb_d  = 1'b0;
            dmem_web_d  = (bus.mem_wstrb != 4'hF);
            dmem_addr_d = {1'b0, bus.mem_addr[ADDR_WIDTH+1:2]};
            dmem_din_d  = bus.mem_wdata;
          end
        end else if (bus.ld_valid && !ld_ready_q) begin
          imem_csb_d  = 1'b0;
          imem_web_d  = 1'b0;
          imem_addr_d = {1'b0, bus.ld_addr};
          imem_din_d  = bus.ld_data;
        end
      end
      S_RD_CAPT: begin
        if (req_wstrb_q != 4'h0) begin
          dmem_csb_d  = 1'b0;
          dmem_web_d  = 1'b0;
          dmem_addr_d = {1'b0, req_idx_q};
          dmem_din_d  = merged;
        end else begin
          rdata_d     = rd_word;
          mem_ready_d = 1'b1;
        end
      end
      S_WRITE:    mem_ready_d = 1'b1;
      S_LD_WRITE: ld_ready_d  = 1'b1;
      default: ;
    endcase
  end

  assign bus.mem_ready = mem_ready_q;
  assign bus.mem_rdata = rdata_q;
  assign bus.oob_err   = oob_err_q;
  assign bus.ld_ready  = ld_ready_q;

  assign imem_csb  = imem_csb_q;
  assign imem_web  = imem_web_q;
  assign imem_addr = imem_addr_q;
  assign imem_din  = imem_din_q;
  assign dmem_csb  = dmem_csb_q;
  assign dmem_web  = dmem_web_q;
  assign dmem_addr = dmem_addr_q;
  assign dmem_din  = dmem_din_q;

endmodule

`default_nettype wire

// File: tb/tb_picorv32_sram_responder.sv
// ============================================================================
// Module   : tb_picorv32_sram_responder
// Purpose  : Directed bench with behavioural 32x32 macro models.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_picorv32_sram_responder;

  logic        clk = 1'b0;
  logic        resetn;
  logic        imem_csb, imem_web, dmem_csb, dmem_web;
  logic [5:0]  imem_addr, dmem_addr;
  logic [31:0] imem_din, dmem_din;
  logic [31:0] imem_dout, dmem_dout;

  logic [31:0] imem_m [0:63];
  logic [31:0] dmem_m [0:63];
  logic        bd_we, bd_imem;
  logic [5:0]  bd_addr;
  logic [31:0] bd_data;

  int checks = 0;
  int errors = 0;

  picorv32_sram_responder_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();

  picorv32_sram_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .bus       (bus),
    .imem_csb  (imem_csb),
    .imem_web  (imem_web),
    .imem_addr (imem_addr),
    .imem_din  (imem_din),
    .imem_dout (imem_dout),
    .dmem_csb  (dmem_csb),
    .dmem_web  (dmem_web),
    .dmem_addr (dmem_addr),
    .dmem_din  (dmem_din),
    .dmem_dout (dmem_dout)
  );

  always #5 clk = ~clk;

  // Macro models: controls sampled on the rising edge, read data next cycle.
  always @(posedge clk) begin
    if (bd_we && bd_imem) imem_m[bd_addr] <= bd_data;
    else if (!imem_csb) begin
      if (!imem_web) imem_m[imem_addr] <= imem_din;
      else           imem_dout <= imem_m[imem_addr];
    end
  end

  always @(posedge clk) begin
    if (bd_we && !bd_imem) dmem_m[bd_addr] <= bd_data;
    else if (!dmem_csb) begin
      if (!dmem_web) dmem_m[dmem_addr] <= dmem_din;
      else           dmem_dout <= dmem_m[dmem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bd_write(input logic imem_sel, input logic [5:0] a, input logic [31:0] d);
    @(negedge clk);
    bd_we = 1'b1; bd_imem = imem_sel; bd_addr = a; bd_data = d;
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  // One CPU transaction; request inputs are scrambled after acceptance.
  task automatic cpu_req(input string tag, input logic instr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] wstrb,
                         input int exp_lat, input logic exp_oob, input logic [31:0] exp_rdata);
    int   lat;
    logic csb_low;
    @(posedge clk); #1;
    bus.mem_valid = 1'b1; bus.mem_instr = instr; bus.mem_addr = addr;
    bus.mem_wdata = wdata; bus.mem_wstrb = wstrb;
    lat = 0; csb_low = 1'b0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (!imem_csb || !dmem_csb) csb_low = 1'b1;
      if (!bus.mem_ready) begin
        bus.mem_addr = 32'h0000_001C; bus.mem_wdata = ~wdata;
        bus.mem_wstrb = ~wstrb; bus.mem_instr = ~instr;
      end
    end while (!bus.mem_ready && lat < 12);
    if (!bus.mem_ready) lat = 99;
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_oob"}, {31'd0, bus.oob_err}, {31'd0, exp_oob});
    chk({tag, "_rdata"}, bus.mem_rdata, exp_rdata);
    if (exp_oob) chk({tag, "_csb"}, {31'd0, csb_low}, 32'd0);
    bus.mem_valid = 1'b0; bus.mem_wstrb = 4'h0; bus.mem_instr = 1'b0;
    @(posedge clk); #1;
    chk({tag, "_pulse"}, {31'd0, bus.mem_ready}, 32'd0);
  endtask

  initial begin
    int mem_cyc, ld_cyc, cyc;
    logic saw_ready;
    resetn = 1'b0;
    bd_we = 1'b0; bd_imem = 1'b0; bd_addr = '0; bd_data = '0;
    bus.mem_valid = 1'b0; bus.mem_instr = 1'b0; bus.mem_addr = '0;
    bus.mem_wdata = '0; bus.mem_wstrb = '0;
    bus.ld_valid = 1'b0; bus.ld_addr = '0; bus.ld_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ctl", {25'd0, imem_csb, imem_web, dmem_csb, dmem_web,
                    bus.mem_ready, bus.ld_ready, bus.oob_err}, 32'b1111000);
    chk("rst_rdata", bus.mem_rdata, 32'h0);
    chk("rst_addr", {20'd0, imem_addr, dmem_addr}, 32'h0);

    bd_write(1'b0, 6'd3, 32'hDEAD_BEEF);
    bd_write(1'b0, 6'd2, 32'h1122_3344);
    bd_write(1'b0, 6'd4, 32'hAAAA_AAAA);
    bd_write(1'b1, 6'd5, 32'h5A5A_5A5A);
    bd_write(1'b1, 6'd0, 32'h0000_0013);
    @(posedge clk); #1;
    resetn = 1'b1;

    cpu_req("rd_dmem3", 1'b0, 32'h0000_000C, 32'h0, 4'h0, 3, 1'b0, 32'hDEAD_BEEF);
    cpu_req("st_full", 1'b0, 32'h0000_0014, 32'hCAFE_F00D, 4'hF, 2, 1'b0, 32'hDEAD_BEEF);
    cpu_req("rd_full", 1'b0, 32'h0000_0014, 32'h0, 4'h0, 3, 1'b0, 32'hCAFE_F00D);
    chk("imem_untouched", imem_m[5], 32'h5A5A_5A5A);
    cpu_req("st_part", 1'b0, 32'h0000_0008, 32'h0000_AB00, 4'b0010, 4, 1'b0, 32'hCAFE_F00D);
    cpu_req("rd_part", 1'b0, 32'h0000_0008, 32'h0, 4'h0, 3, 1'b0, 32'h1122_AB44);

    // Loader-only write, then fetch it back.
    @(posedge clk); #1;
    bus.ld_valid = 1'b1; bus.ld_addr = 5'd1; bus.ld_data = 32'h0050_0093;
    cyc = 0;
    do begin @(posedge clk); #1; cyc++; end while (!bus.ld_ready && cyc < 12);
    if (!bus.ld_ready) cyc = 99;
    chk("ld_lat", cyc, 2);
    bus.ld_valid = 1'b0;
    @(posedge clk); #1;
    chk("ld_pulse", {31'd0, bus.ld_ready}, 32'd0);
    cpu_req("fetch_ld", 1'b1, 32'h0000_0004, 32'h0, 4'h0, 3, 1'b0, 32'h0050_0093);

    // Simultaneous loader and CPU request: CPU served first.
    @(posedge clk); #1;
    bus.ld_valid = 1'b1; bus.ld_addr = 5'd2; bus.ld_data = 32'h1234_5678;
    bus.mem_valid = 1'b1; bus.mem_instr = 1'b1; bus.mem_addr = 32'h0; bus.mem_wstrb = 4'h0;
    mem_cyc = 99; ld_cyc = 99; cyc = 0;
    do begin
      @(posedge clk); #1; cyc++;
      if (bus.mem_ready && mem_cyc == 99) begin
        mem_cyc = cyc; bus.mem_valid = 1'b0;
        chk("arb_rdata", bus.mem_rdata, 32'h0000_0013);
      end
      if (bus.ld_ready && ld_cyc == 99) begin ld_cyc = cyc; bus.ld_valid = 1'b0; end
    end while ((mem_cyc == 99 || ld_cyc == 99) && cyc < 20);
    bus.mem_valid = 1'b0; bus.ld_valid = 1'b0; bus.mem_instr = 1'b0;
    chk("arb_mem_cyc", mem_cyc, 3);
    chk("arb_ld_cyc", ld_cyc, 6);
    chk("arb_imem2", imem_m[2], 32'h1234_5678);

    cpu_req("oob_high", 1'b0, 32'h0000_0080, 32'h0, 4'h0, 1, 1'b1, 32'h0);
    cpu_req("rd_after_oob", 1'b0, 32'h0000_000C, 32'h0, 4'h0, 3, 1'b0, 32'hDEAD_BEEF);
    cpu_req("oob_misal", 1'b0, 32'h0000_0006, 32'h0, 4'h0, 1, 1'b1, 32'h0);

    // Partial store aborted by reset during the capture cycle.
    @(posedge clk); #1;
    bus.mem_valid = 1'b1; bus.mem_instr = 1'b0; bus.mem_addr = 32'h0000_0010;
    bus.mem_wdata = 32'h0000_00FF; bus.mem_wstrb = 4'b0001;
    @(posedge clk); #1;
    @(posedge clk); #1;
    resetn = 1'b0;
    #1;
    chk("abort_ctl", {28'd0, dmem_csb, dmem_web, bus.mem_ready, bus.oob_err}, 32'b1100);
    chk("abort_din", dmem_din, 32'h0);
    chk("abort_rdata", bus.mem_rdata, 32'h0);
    bus.mem_valid = 1'b0; bus.mem_wstrb = 4'h0;
    saw_ready = 1'b0;
    repeat (3) begin @(posedge clk); #1; if (bus.mem_ready) saw_ready = 1'b1; end
    resetn = 1'b1;
    repeat (4) begin @(posedge clk); #1; if (bus.mem_ready) saw_ready = 1'b1; end
    chk("abort_noready", {31'd0, saw_ready}, 32'd0);
    chk("abort_dmem4", dmem_m[4], 32'hAAAA_AAAA);
    cpu_req("rd_after_abort", 1'b0, 32'h0000_0010, 32'h0, 4'h0, 3, 1'b0, 32'hAAAA_AAAA);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/picorv32_sram_responder.md
Name: picorv32_sram_responder

Overview:
Memory-side responder for the PicoRV32 native memory interface. It replaces the hard-wired mem_ready=1 hookup with a real valid/ready handshake to two sky130 OpenRAM 32x32 macros, one for instructions (imem) and one for data (dmem). It absorbs the macro read latency and builds byte-strobe stores by read-modify-write. It also provides a word-write loader port so a future UART loader can fill imem.

Parameters:
DATA_WIDTH, 32, word width; fixed at 32 for PicoRV32.
ADDR_WIDTH, 5, macro word-address width; the macro port is ADDR_WIDTH+1 wide and its MSB is driven 0.

Ports:
clk  input  1  single clock
resetn  input  1  asynchronous active-low reset
mem_valid  input  1  CPU request valid
mem_instr  input  1  1 = instruction fetch (imem), 0 = data (dmem)
mem_addr  input  32  byte address
mem_wdata  input  32  store data
mem_wstrb  input  4  byte strobes; 0 = read
mem_ready  output  1  one-cycle completion pulse
mem_rdata  output  32  read data, valid while mem_ready=1
oob_err  output  1  pulses with mem_ready on an out-of-range or misaligned request
ld_valid  input  1  loader imem write request
ld_addr  input  ADDR_WIDTH  loader word address
ld_data  input  32  loader word
ld_ready  output  1  one-cycle loader-write-done pulse
imem_csb, dmem_csb  output  1 each  macro chip select, active-low
imem_web, dmem_web  output  1 each  macro write enable, active-low
imem_addr, dmem_addr  output  ADDR_WIDTH+1 each  macro word address
imem_din, dmem_din  output  32 each  macro write data
imem_dout, dmem_dout  input  32 each  macro read data

Behaviour:
- Reset (async, resetn=0):
  - state=IDLE; mem_ready=0; ld_ready=0; oob_err=0; mem_rdata=0.
  - csb=1 and web=1 on both macros; addr and din = 0.
  - Reset mid-transaction aborts it. No write is issued after reset asserts, and no mem_ready is produced for the aborted request.
- All macro control outputs are registered. The macro samples controls at the rising edge that ends the cycle in which they are driven. Read data is valid on dout in the following cycle.
- Word index = mem_addr[ADDR_WIDTH+1:2].
- Out-of-range request: mem_addr[31:ADDR_WIDTH+2]!=0, or mem_addr[1:0]!=0.
- Target macro: imem if mem_instr=1, else dmem. Stores with mem_instr=0 target dmem; the CPU never writes imem.
- States: IDLE, RD_ISSUE, RD_CAPT, WRITE, RESP, LD_WRITE.
- Transitions from IDLE (request seen in cycle N):
  - mem_valid & out-of-range: go to RESP directly, no macro access. In cycle N+1: mem_ready=1, oob_err=1, mem_rdata=0.
  - mem_valid & wstrb==0: RD_ISSUE (csb=0, web=1), then RD_CAPT (mem_rdata<=dout), then RESP. mem_ready=1 in cycle N+3.
  - mem_valid & wstrb==4'hF: WRITE (csb=0, web=0, din=wdata), then RESP. mem_ready=1 in cycle N+2.
  - mem_valid & partial wstrb: RD_ISSUE, then RD_CAPT (merge: byte i = wstrb[i] ? wdata byte i : dout byte i), then WRITE with the merged word, then RESP. mem_ready=1 in cycle N+4.
  - ~mem_valid & ld_valid: LD_WRITE (imem csb=0, web=0, addr=ld_addr, din=ld_data), then IDLE with ld_ready=1 for one cycle.
- Arbitration: if mem_valid and ld_valid are both high in IDLE, the CPU wins. The loader waits, holding ld_valid/ld_addr/ld_data stable until ld_ready.
- RESP:
  - mem_ready=1 for exactly one cycle, then IDLE.
  - mem_rdata is held until the next read completes.
  - For stores, mem_rdata is unchanged.
- mem_addr, wdata, wstrb and instr are latched in IDLE on accept. Later input changes are ignored until RESP.
- In IDLE, csb=1 on both macros (no spurious accesses).
- Back-to-back: a new mem_valid in the cycle after RESP is accepted immediately.

Test Plan:
- Preload dmem[3]=0xDEADBEEF; read with mem_addr=0x0C, wstrb=0, instr=0 -> mem_ready in cycle N+3, mem_rdata=0xDEADBEEF, oob_err=0.
- Store mem_addr=0x14, wdata=0xCAFEF00D, wstrb=4'hF -> mem_ready at N+2; a subsequent read returns 0xCAFEF00D; imem is untouched.
- dmem[2]=0x11223344; store addr=0x08, wdata=0x0000AB00, wstrb=4'b0010 -> mem_ready at N+4; readback = 0x1122AB44.
- Loader writes imem[1]=0x00500093, ld_ready seen; fetch with addr=0x04, instr=1 -> mem_rdata=0x00500093. Repeat with ld_valid and mem_valid raised together -> CPU response first, then ld_ready.
- Read addr=0x80 and read addr=0x06 -> each gives mem_ready at N+1, oob_err=1, mem_rdata=0, and both csb stay high.
- Partial store to dmem[4]=0xAAAAAAAA; assert resetn=0 during RD_CAPT -> outputs reach reset values immediately, no mem_ready, and dmem[4] reads 0xAAAAAAAA after reset.
